// File: rtl/dadda_cpa_serial.sv
// Dadda-tree final CPA: adds sum/carry rows CHUNK bits per cycle, result valid WIDTH/CHUNK cycles after accept.
// Result is held in DONE until io_out_ready; no new rows accepted outside IDLE. Carry-out port under DADDA_CPA_COUT_EN.
module dadda_cpa_serial #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             io_in_valid,
   output logic             io_in_ready,
   input  logic [WIDTH-1:0] io_in_a,
   input  logic [WIDTH-1:0] io_in_b,
   output logic             io_out_valid,
   input  logic             io_out_ready,
   output logic [WIDTH-1:0] io_out_sum
`ifdef DADDA_CPA_COUT_EN
   ,
   output logic             io_out_cout
`endif
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sum_q;
   logic             carry_q;
   logic [IDXW-1:0]  idx_q;

   logic [CHUNK-1:0] a_chunk;
   logic [CHUNK-1:0] b_chunk;
   logic [CHUNK:0]   chunk_add;
   logic             last_chunk;

   // Chunk select is a mux over constant slices so every part-select stays in range.
   always_comb begin
      a_chunk = '0;
      b_chunk = '0;
      for (int j = 0; j < NCHUNK; j++) begin
         if (idx_q == IDXW'(j)) begin
            a_chunk = a_q[j*CHUNK +: CHUNK];
            b_chunk = b_q[j*CHUNK +: CHUNK];
         end
      end
      chunk_add = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
   end

   assign last_chunk = (idx_q == IDXW'(NCHUNK - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (io_in_valid) begin
                  a_q     <= io_in_a;
                  b_q     <= io_in_b;
                  carry_q <= 1'b0;
                  idx_q   <= '0;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               for (int j = 0; j < NCHUNK; j++) begin
                  if (idx_q == IDXW'(j)) begin
                     sum_q[j*CHUNK +: CHUNK] <= chunk_add[CHUNK-1:0];
                  end
               end
               carry_q <= chunk_add[CHUNK];
               idx_q   <= idx_q + 1'b1;
               if (last_chunk) begin
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (io_out_ready) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Handshake outputs come from state only, so no input-to-output path exists.
   assign io_in_ready  = (state_q == IDLE);
   assign io_out_valid = (state_q == DONE);
   assign io_out_sum   = sum_q;

`ifdef DADDA_CPA_COUT_EN
   assign io_out_cout = carry_q;
`endif

endmodule
